// File: rtl/sipo_frame_ctrl.sv
// Serial-to-parallel framing controller: detects start bit, shifts WIDTH data bits,
// checks the stop bit and hands each word to a consumer through a one-word valid/ready buffer.
module sipo_frame_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sdi,
    output logic [WIDTH-1:0] frame_data,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             busy,
    output logic             framing_err,
    output logic             overrun_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_STOP
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sr_reg, sr_next, sr_shifted;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             ferr_reg, ferr_next;
    logic             oerr_reg, oerr_next;
    logic             accept;

    // Shift-register input path; the bit order is fixed at elaboration time.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_in
                    assign sr_shifted[gi] = sdi;
                end else begin : g_mid
                    assign sr_shifted[gi] = sr_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_in
                    assign sr_shifted[gi] = sdi;
                end else begin : g_mid
                    assign sr_shifted[gi] = sr_reg[gi+1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            sr_reg    <= '0;
            cnt_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            oerr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sr_reg    <= sr_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
            oerr_reg  <= oerr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        accept     = valid_reg && frame_ready;
        valid_next = valid_reg && !accept;
        ferr_next  = 1'b0;
        oerr_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (en && sdi) begin
                    state_next = ST_SHIFT;
                    sr_next    = '0;
                    cnt_next   = '0;
                end
            end
            ST_SHIFT: begin
                if (!en) begin
                    state_next = ST_IDLE;
                    sr_next    = '0;
                    cnt_next   = '0;
                end else begin
                    sr_next  = sr_shifted;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                state_next = ST_IDLE;
                sr_next    = '0;
                cnt_next   = '0;
                if (en) begin
                    if (sdi) begin
                        ferr_next = 1'b1;
                    end else if (!valid_reg || accept) begin
                        // A word consumed on this edge frees the slot for the new one.
                        data_next  = sr_reg;
                        valid_next = 1'b1;
                    end else begin
                        oerr_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                sr_next    = '0;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy        = (state_reg == ST_SHIFT) || (state_reg == ST_STOP);
    assign frame_data  = data_reg;
    assign frame_valid = valid_reg;
    assign framing_err = ferr_reg;
    assign overrun_err = oerr_reg;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Randomized bench for sipo_frame_ctrl: MSB-first and LSB-first instances share stimulus and
// are compared against a frame-level model of the one-word output buffer.
module tb_sipo_frame_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic         sdi = 1'b0;
    logic         frame_ready = 1'b0;
    logic [W-1:0] data_m, data_l;
    logic         valid_m, valid_l, busy_m, busy_l;
    logic         ferr_m, ferr_l, oerr_m, oerr_l;

    int errors = 0;
    int checks = 0;

    bit           mv_m = 1'b0, mv_l = 1'b0;
    logic [W-1:0] md_m = '0, md_l = '0;

    always #5 clk = ~clk;

    sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset_n(reset_n), .en(en), .sdi(sdi),
        .frame_data(data_m), .frame_valid(valid_m), .frame_ready(frame_ready),
        .busy(busy_m), .framing_err(ferr_m), .overrun_err(oerr_m)
    );

    sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset_n(reset_n), .en(en), .sdi(sdi),
        .frame_data(data_l), .frame_valid(valid_l), .frame_ready(frame_ready),
        .busy(busy_l), .framing_err(ferr_l), .overrun_err(oerr_l)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One-word buffer semantics at a single clock edge.
    function automatic void buf_step(input bit v, input logic [W-1:0] d, input bit rdy,
                                     input bit good, input logic [W-1:0] w,
                                     output bit nv, output logic [W-1:0] nd, output bit ov);
        bit acc;
        acc = v && rdy;
        nv  = v;
        nd  = d;
        ov  = 1'b0;
        if (good) begin
            if (!v || acc) begin
                nv = 1'b1;
                nd = w;
            end else begin
                ov = 1'b1;
            end
        end else if (acc) begin
            nv = 1'b0;
        end
    endfunction

    // kind: 0 = no frame completes, 1 = good stop bit, 2 = bad stop bit
    task automatic tick(input bit rst_v, input bit en_v, input bit sdi_v, input bit rdy_v,
                        input int kind, input logic [W-1:0] word_m, input logic [W-1:0] word_l,
                        input bit exp_busy);
        bit exp_fe, exp_ovm, exp_ovl, nv;
        logic [W-1:0] nd;
        reset_n     = rst_v;
        en          = en_v;
        sdi         = sdi_v;
        frame_ready = rdy_v;
        @(posedge clk);
        exp_fe  = 1'b0;
        exp_ovm = 1'b0;
        exp_ovl = 1'b0;
        if (!rst_v) begin
            mv_m = 1'b0; md_m = '0;
            mv_l = 1'b0; md_l = '0;
        end else begin
            buf_step(mv_m, md_m, rdy_v, kind == 1, word_m, nv, nd, exp_ovm);
            mv_m = nv; md_m = nd;
            buf_step(mv_l, md_l, rdy_v, kind == 1, word_l, nv, nd, exp_ovl);
            mv_l = nv; md_l = nd;
            exp_fe = (kind == 2);
        end
        #1;
        check_value("valid_msb", 32'(valid_m), 32'(mv_m));
        check_value("valid_lsb", 32'(valid_l), 32'(mv_l));
        if (mv_m || !rst_v) check_value("data_msb", 32'(data_m), 32'(md_m));
        if (mv_l || !rst_v) check_value("data_lsb", 32'(data_l), 32'(md_l));
        check_value("busy_msb", 32'(busy_m), 32'(exp_busy && rst_v));
        check_value("busy_lsb", 32'(busy_l), 32'(exp_busy && rst_v));
        check_value("ferr_msb", 32'(ferr_m), 32'(exp_fe));
        check_value("ferr_lsb", 32'(ferr_l), 32'(exp_fe));
        check_value("oerr_msb", 32'(oerr_m), 32'(exp_ovm));
        check_value("oerr_lsb", 32'(oerr_l), 32'(exp_ovl));
    endtask

    function automatic bit pick_rdy(input int mode);
        if (mode == 2) return 1'($urandom);
        return mode[0];
    endfunction

    // Idle cycles: sdi held low while enabled; arbitrary sdi while disabled.
    task automatic idle(input int n, input int rdy_mode);
        bit e;
        for (int i = 0; i < n; i++) begin
            e = 1'($urandom);
            tick(1'b1, e, e ? 1'b0 : 1'($urandom), pick_rdy(rdy_mode), 0, '0, '0, 1'b0);
        end
    endtask

    // bits_v[W-1] goes out first. abort_at = number of data bits sent before the abort
    // (-1: none); abort_rst selects reset instead of en low as the abort.
    task automatic send_frame(input logic [W-1:0] bits_v, input bit stop_v, input int abort_at,
                              input bit abort_rst, input int rdy_mode, input int stop_rdy);
        logic [W-1:0] word_m, word_l;
        bit r;
        word_m = bits_v;
        for (int i = 0; i < W; i++) word_l[i] = bits_v[W-1-i];
        tick(1'b1, 1'b1, 1'b1, pick_rdy(rdy_mode), 0, '0, '0, 1'b1);
        for (int i = 0; i <= W; i++) begin
            if (abort_at == i) begin
                tick(!abort_rst, abort_rst, 1'($urandom), pick_rdy(rdy_mode), 0, '0, '0, 1'b0);
                $display("frame bits=%b stop=%b aborted_after=%0d by_reset=%0d", bits_v, stop_v,
                         abort_at, abort_rst);
                return;
            end
            if (i < W) tick(1'b1, 1'b1, bits_v[W-1-i], pick_rdy(rdy_mode), 0, '0, '0, 1'b1);
        end
        r = (stop_rdy < 0) ? pick_rdy(rdy_mode) : stop_rdy[0];
        tick(1'b1, 1'b1, stop_v, r, stop_v ? 2 : 1, word_m, word_l, 1'b0);
        $display("frame bits=%b stop=%b ready_at_stop=%b -> valid=%b data_msb=%b data_lsb=%b",
                 bits_v, stop_v, r, valid_m, data_m, data_l);
    endtask

    initial begin
        int kind, ab;
        // Reset held with start-like input present
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b1, 0, '0, '0, 1'b0);
        idle(1, 0);

        // Good frame 1010, consumed on the following cycle
        send_frame(4'b1010, 1'b0, -1, 1'b0, 0, -1);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 0, '0, '0, 1'b0);

        // Bad stop bit
        send_frame(4'b0110, 1'b1, -1, 1'b0, 0, -1);

        // Overrun, then same-edge accept and reload
        send_frame(4'b1100, 1'b0, -1, 1'b0, 0, -1);
        send_frame(4'b0011, 1'b0, -1, 1'b0, 0, -1);
        send_frame(4'b0011, 1'b0, -1, 1'b0, 0, 1);
        idle(1, 1);

        // First-bit placement check for the LSB-first instance
        send_frame(4'b1000, 1'b0, -1, 1'b0, 0, -1);
        idle(1, 1);

        // Aborts by en and by reset, then a clean frame
        send_frame(4'b1001, 1'b0, 2, 1'b0, 0, -1);
        send_frame(4'b1001, 1'b0, 2, 1'b1, 0, -1);
        send_frame(4'b1001, 1'b0, -1, 1'b0, 0, -1);
        idle(2, 1);

        // Randomized traffic with back-to-back frames allowed
        for (int f = 0; f < 200; f++) begin
            idle($urandom_range(0, 3), 2);
            kind = $urandom_range(0, 99);
            ab   = (kind >= 85) ? $urandom_range(0, W) : -1;
            send_frame(4'($urandom), (kind >= 70 && kind < 85), ab, (kind >= 95), 2, -1);
        end
        idle(3, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
